ctrl_seq_unit: RTL and testbench

//  Multi-cycle control sequencer: successor to the combinational opcode-ROM decoder, now with internal state.

---
 rtl/ctrl_pkg.sv | 120 ++++++++++++
 rtl/ctrl_decode_rom.sv | 30 +++
 rtl/ctrl_seq_unit.sv | 190 +++++++++++++++++++
 tb/tb_ctrl_seq_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: state encoding, mux-select codes,
// trap causes, opcode values, the control-word layout and the per-opcode decode rule.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  // PC source mux
  localparam logic [2:0] PCSEL_INC   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JMP   = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;
  localparam logic [2:0] PCSEL_XADR  = 3'd4;

  // Register-file write-data mux
  localparam logic [1:0] WDSEL_PC4 = 2'd0;
  localparam logic [1:0] WDSEL_ALU = 2'd1;
  localparam logic [1:0] WDSEL_MEM = 2'd2;

  // Trap causes, reported until the next trap overwrites them
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLOP    = 2'd1;
  localparam logic [1:0] CAUSE_IRQ      = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TMO = 2'd3;

  localparam logic [5:0] OPC_LD  = 6'h18;
  localparam logic [5:0] OPC_ST  = 6'h19;
  localparam logic [5:0] OPC_JMP = 6'h1B;
  localparam logic [5:0] OPC_BEQ = 6'h1D;
  localparam logic [5:0] OPC_BNE = 6'h1E;
  localparam logic [5:0] OPC_LDR = 6'h1F;

  // The control word carries the widest ALU function we support; the
  // instantiating logic masks/truncates it to its own ALUFN_W.
  localparam int CW_ALUFN_W = 8;
  localparam logic [CW_ALUFN_W-1:0] ALUFN_ADD = 8'h20;

  // How EXEC chooses the next PC; branches resolve on Z in EXEC itself.
  typedef enum logic [1:0] {
    PK_INC = 2'd0,
    PK_JMP = 2'd1,
    PK_BEQ = 2'd2,
    PK_BNE = 2'd3
  } pc_kind_t;

  typedef struct packed {
    logic                  valid;
    logic [CW_ALUFN_W-1:0] alufn;
    pc_kind_t              pcsel_kind;
    logic                  ra2sel;
    logic                  asel;
    logic                  bsel;
    logic [1:0]            wdsel;   // for memory ops: the select used in the ACK cycle
    logic                  wr;
    logic                  werf;    // for memory ops: write-back in the ACK cycle
    logic                  is_mem;
  } ctrl_word_t;

  // One row of the 64-entry decode table. ALU ops (upper half) pass the
  // opcode through as the ALU function; bit 4 selects the constant form.
  function automatic ctrl_word_t decode_op(input logic [5:0] op);
    ctrl_word_t cw;
    cw            = '0;
    cw.pcsel_kind = PK_INC;
    if (op[5]) begin
      cw.valid = 1'b1;
      cw.alufn = CW_ALUFN_W'(op);
      cw.bsel  = op[4];
      cw.wdsel = WDSEL_ALU;
      cw.werf  = 1'b1;
    end else begin
      case (op)
        OPC_LD, OPC_LDR: begin
          cw.valid  = 1'b1;
          cw.alufn  = ALUFN_ADD;
          cw.bsel   = 1'b1;
          cw.asel   = (op == OPC_LDR);
          cw.wdsel  = WDSEL_MEM;
          cw.werf   = 1'b1;
          cw.is_mem = 1'b1;
        end
        OPC_ST: begin
          cw.valid  = 1'b1;
          cw.alufn  = ALUFN_ADD;
          cw.bsel   = 1'b1;
          cw.ra2sel = 1'b1;
          cw.wr     = 1'b1;
          cw.is_mem = 1'b1;
        end
        OPC_JMP: begin
          cw.valid      = 1'b1;
          cw.pcsel_kind = PK_JMP;
          cw.wdsel      = WDSEL_PC4;
          cw.werf       = 1'b1;
        end
        OPC_BEQ: begin
          cw.valid      = 1'b1;
          cw.pcsel_kind = PK_BEQ;
          cw.wdsel      = WDSEL_PC4;
          cw.werf       = 1'b1;
        end
        OPC_BNE: begin
          cw.valid      = 1'b1;
          cw.pcsel_kind = PK_BNE;
          cw.wdsel      = WDSEL_PC4;
          cw.werf       = 1'b1;
        end
        default: cw = '0;
      endcase
    end
    return cw;
  endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// Opcode decode table: maps an opcode to its control word; rows at or above 64 are illegal.
// Latency: combinational. Backpressure: none.
// Ports: opcode (OP_W) in; cw (ctrl_word_t) out, alufn masked to ALUFN_W bits.
module ctrl_decode_rom
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUFN_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  output ctrl_word_t      cw
);

  localparam logic [CW_ALUFN_W-1:0] ALUFN_MASK = CW_ALUFN_W'((1 << ALUFN_W) - 1);

  logic [31:0] op_ext;
  ctrl_word_t  raw;

  always_comb begin
    op_ext = 32'(opcode);
    raw    = decode_op(op_ext[5:0]);
    // Only 64 rows are defined; anything wider decodes as an invalid entry.
    if (op_ext >= 32'd64) begin
      raw = '0;
    end
    cw       = raw;
    cw.alufn = raw.alufn & ALUFN_MASK;
  end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/TRAP driving datapath selects and memory handshakes.
// Latency: ALU/branch 3 cycles min, LD/ST 4 cycles min (zero-wait ACKs); traps add one cycle.
// Backpressure: IMEM_REQ/DMEM_REQ held until the matching ACK; DMEM wait bounded by MEM_TMO (0 = unbounded).
// Ports: clk, reset_n (async active-low); opcode/z/irq/supervisor/imem_ack/dmem_ack in;
//        imem_req, dmem_req, ir_en, pc_en, pcsel, ra2sel, asel, bsel, wasel, wdsel, alufn, wr, werf, trap_cause out.
module ctrl_seq_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUFN_W = 6,
  parameter int MEM_TMO = 15,
  parameter int IRQ_EN  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               z,
  input  logic               irq,
  input  logic               supervisor,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               ir_en,
  output logic               pc_en,
  output logic [2:0]         pcsel,
  output logic               ra2sel,
  output logic               asel,
  output logic               bsel,
  output logic               wasel,
  output logic [1:0]         wdsel,
  output logic [ALUFN_W-1:0] alufn,
  output logic               wr,
  output logic               werf,
  output logic [1:0]         trap_cause
);

  // Wait counter counts MEM cycles without ACK: 0 .. MEM_TMO-1.
  localparam int CNT_W      = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
  localparam int TMO_LAST_I = (MEM_TMO > 0) ? MEM_TMO - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

  state_t          state;
  logic [OP_W-1:0] op_q;
  ctrl_word_t      cw_q;
  ctrl_word_t      rom_cw;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]      cause_q;
  logic            irq_take;
  logic            tmo_hit;

  ctrl_decode_rom #(
    .OP_W    (OP_W),
    .ALUFN_W (ALUFN_W)
  ) u_decode_rom (
    .opcode (op_q),
    .cw     (rom_cw)
  );

  assign irq_take = (IRQ_EN != 0) && irq && !supervisor;
  assign tmo_hit  = (MEM_TMO != 0) && (wait_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_FETCH;
      op_q     <= '0;
      cw_q     <= '0;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      case (state)
        ST_FETCH: begin
          // An unmasked IRQ wins over a fetch that happens to complete this cycle.
          if (irq_take) begin
            state   <= ST_TRAP;
            cause_q <= CAUSE_IRQ;
          end else if (imem_ack) begin
            op_q  <= opcode;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          cw_q <= rom_cw;
          if (rom_cw.valid) begin
            state <= ST_EXEC;
          end else begin
            state   <= ST_TRAP;
            cause_q <= CAUSE_ILLOP;
          end
        end
        ST_EXEC: begin
          wait_cnt <= '0;
          state    <= cw_q.is_mem ? ST_MEM : ST_FETCH;
        end
        ST_MEM: begin
          // A real ACK in the last allowed wait cycle still completes the access.
          if (dmem_ack) begin
            wait_cnt <= '0;
            state    <= ST_FETCH;
          end else if (tmo_hit) begin
            wait_cnt <= '0;
            state    <= ST_TRAP;
            cause_q  <= CAUSE_DMEM_TMO;
          end else if (MEM_TMO != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_TRAP: begin
          state <= ST_FETCH;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Outputs decode registered state/control word, qualified by the ACK and Z
  // inputs of the current cycle. Everything is forced low while reset is
  // asserted so a reset mid-access drops REQ/WR/WERF without waiting for a clock.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pcsel    = PCSEL_INC;
    ra2sel   = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    wasel    = 1'b0;
    wdsel    = WDSEL_PC4;
    alufn    = '0;
    wr       = 1'b0;
    werf     = 1'b0;
    if (reset_n) begin
      case (state)
        ST_FETCH: begin
          if (!irq_take) begin
            imem_req = 1'b1;
            ir_en    = imem_ack;
          end
        end
        ST_EXEC: begin
          if (cw_q.valid) begin
            alufn  = ALUFN_W'(cw_q.alufn);
            ra2sel = cw_q.ra2sel;
            asel   = cw_q.asel;
            bsel   = cw_q.bsel;
            if (!cw_q.is_mem) begin
              werf  = cw_q.werf;
              wdsel = cw_q.wdsel;
              pc_en = 1'b1;
              case (cw_q.pcsel_kind)
                PK_JMP:  pcsel = PCSEL_JMP;
                PK_BEQ:  pcsel = z ? PCSEL_BR : PCSEL_INC;
                PK_BNE:  pcsel = z ? PCSEL_INC : PCSEL_BR;
                default: pcsel = PCSEL_INC;
              endcase
            end
          end
        end
        ST_MEM: begin
          // Address/data selects stay put for the whole access.
          alufn    = ALUFN_W'(cw_q.alufn);
          ra2sel   = cw_q.ra2sel;
          asel     = cw_q.asel;
          bsel     = cw_q.bsel;
          dmem_req = 1'b1;
          wr       = cw_q.wr;
          if (dmem_ack) begin
            pc_en = 1'b1;
            werf  = cw_q.werf;
            wdsel = cw_q.wdsel;
          end
        end
        ST_TRAP: begin
          wasel = 1'b1;
          werf  = 1'b1;
          pc_en = 1'b1;
          wdsel = WDSEL_PC4;
          pcsel = (cause_q == CAUSE_IRQ) ? PCSEL_XADR : PCSEL_ILLOP;
        end
        default: ;
      endcase
    end
  end

  assign trap_cause = cause_q;

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Randomized bench for ctrl_seq_unit: each instruction is expanded into its expected
// per-cycle output trace from the instruction's class, then played against the DUT.
module tb_ctrl_seq_unit;

  localparam int TMO = 4;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       z, irq, supervisor, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, ir_en, pc_en;
  logic [2:0] pcsel;
  logic       ra2sel, asel, bsel, wasel;
  logic [1:0] wdsel;
  logic [5:0] alufn;
  logic       wr, werf;
  logic [1:0] trap_cause;

  ctrl_seq_unit #(.OP_W(6), .ALUFN_W(6), .MEM_TMO(TMO), .IRQ_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .z(z), .irq(irq),
    .supervisor(supervisor), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_en(ir_en), .pc_en(pc_en),
    .pcsel(pcsel), .ra2sel(ra2sel), .asel(asel), .bsel(bsel), .wasel(wasel),
    .wdsel(wdsel), .alufn(alufn), .wr(wr), .werf(werf), .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, ir_en, pc_en;
    logic [2:0] pcsel;
    logic       ra2sel, asel, bsel, wasel;
    logic [1:0] wdsel;
    logic [5:0] alufn;
    logic       wr, werf;
    logic [1:0] trap_cause;
  } obs_t;

  obs_t obs;
  assign obs = {imem_req, dmem_req, ir_en, pc_en, pcsel, ra2sel, asel, bsel, wasel,
                wdsel, alufn, wr, werf, trap_cause};

  int    n_tests = 0;
  int    n_fail  = 0;
  obs_t  exp_cur;
  obs_t  care_cur;
  bit    exp_vld = 1'b0;
  string tag = "";
  int    cyc_no = 0;
  logic [1:0] cur_cause = 2'd0;

  // Per-cycle compare against the expected trace.
  always @(negedge clk) begin
    if (exp_vld) begin
      n_tests++;
      if (((obs ^ exp_cur) & care_cur) != '0) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs %h required %h (care %h)",
                 tag, cyc_no, obs, exp_cur, care_cur);
      end
    end
  end

  // Event monitor for the directed literal checks.
  int         n_dreq = 0, n_wr = 0, n_ir = 0, n_ldwb = 0;
  logic [2:0] last_pcsel = '0;
  logic [1:0] last_wdsel = '0;
  logic       last_werf = 1'b0, last_wasel = 1'b0;
  logic [5:0] last_alufn = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (dmem_req) n_dreq++;
      if (wr) n_wr++;
      if (ir_en) n_ir++;
      if (werf && wdsel == 2'd2) n_ldwb++;
      if (pc_en) begin
        last_pcsel = pcsel;
        last_wdsel = wdsel;
        last_werf  = werf;
        last_wasel = wasel;
        last_alufn = alufn;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t idle();
    obs_t o;
    o = '0;
    o.trap_cause = cur_cause;
    return o;
  endfunction

  // Address/data selects during a memory wait are not part of the contract.
  function automatic obs_t mem_care();
    obs_t m;
    m = '1;
    m.alufn = '0; m.asel = 1'b0; m.bsel = 1'b0; m.ra2sel = 1'b0;
    return m;
  endfunction

  task automatic cyc(input string t, input logic [5:0] op, input logic zv, input logic irqv,
                     input logic supv, input logic ia, input logic da, input obs_t e, input obs_t m);
    @(posedge clk); #1;
    opcode = op; z = zv; irq = irqv; supervisor = supv; imem_ack = ia; dmem_ack = da;
    exp_cur = e; care_cur = m; tag = t; exp_vld = 1'b1; cyc_no++;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic trap(input logic [1:0] cause);
    obs_t e;
    cur_cause = cause;
    e = idle();
    e.wasel = 1'b1; e.werf = 1'b1; e.pc_en = 1'b1;
    e.pcsel = (cause == 2'd2) ? 3'd4 : 3'd3;
    cyc("trap", 6'($urandom), rb(), rb(), rb(), rb(), rb(), e, '1);
  endtask

  task automatic irq_trap();
    cyc("irq_fetch", 6'($urandom), rb(), 1'b1, 1'b0, rb(), rb(), idle(), '1);
    trap(2'd2);
  endtask

  // One instruction: fetch wait idly cycles, ACK, decode, then execute by class.
  // masked=1 holds IRQ high with SUPERVISOR set during fetch.
  task automatic instr(input logic [5:0] op, input int idly, input int ddly,
                       input logic zv, input logic masked);
    obs_t e;
    bit   is_alu, is_mem, is_st, legal;
    is_alu = (op >= 6'h20);
    is_mem = (op == 6'h18) || (op == 6'h19) || (op == 6'h1F);
    is_st  = (op == 6'h19);
    legal  = is_alu || is_mem || (op == 6'h1B) || (op == 6'h1D) || (op == 6'h1E);
    for (int i = 0; i < idly; i++) begin
      e = idle(); e.imem_req = 1'b1;
      cyc("fetch_wait", 6'($urandom), rb(), masked, masked | rb(), 1'b0, rb(), e, '1);
    end
    e = idle(); e.imem_req = 1'b1; e.ir_en = 1'b1;
    cyc("fetch_ack", op, rb(), masked, masked | rb(), 1'b1, rb(), e, '1);
    cyc("decode", 6'($urandom), rb(), rb(), rb(), rb(), rb(), idle(), '1);
    if (!legal) begin
      trap(2'd1);
      return;
    end
    e = idle();
    if (is_mem) begin
      e.alufn = 6'h20; e.bsel = 1'b1; e.asel = (op == 6'h1F); e.ra2sel = is_st;
    end else begin
      e.pc_en = 1'b1; e.werf = 1'b1;
      if (is_alu) begin
        e.alufn = op; e.bsel = op[4]; e.wdsel = 2'd1;
      end else if (op == 6'h1B) e.pcsel = 3'd2;
      else if (op == 6'h1D)     e.pcsel = zv ? 3'd1 : 3'd0;
      else                      e.pcsel = zv ? 3'd0 : 3'd1;
    end
    cyc("exec", 6'($urandom), zv, rb(), rb(), rb(), rb(), e, '1);
    if (!is_mem) return;
    for (int k = 0; k < TMO; k++) begin
      e = idle(); e.dmem_req = 1'b1; e.wr = is_st;
      if (k == ddly) begin
        e.pc_en = 1'b1; e.werf = !is_st; e.wdsel = is_st ? 2'd0 : 2'd2;
        cyc("mem_ack", 6'($urandom), rb(), rb(), rb(), rb(), 1'b1, e, mem_care());
        return;
      end
      cyc("mem_wait", 6'($urandom), rb(), rb(), rb(), rb(), 1'b0, e, mem_care());
    end
    trap(2'd3);
  endtask

  int         b0, b1, r, sel;
  logic [5:0] op;
  obs_t       e;

  initial begin
    reset_n = 1'b0; opcode = '0; z = 1'b0; irq = 1'b0; supervisor = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2 imem_ack = 1'b1; irq = 1'b1; dmem_ack = 1'b1; #1;
    check("reset_outputs_zero", int'(obs), 0);
    check("reset_trap_cause", int'(trap_cause), 0);
    @(negedge clk);
    reset_n = 1'b1; irq = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

    // ADD with IMEM_ACK two cycles late
    b0 = n_ir;
    instr(6'h20, 2, 0, 1'b0, 1'b0); settle();
    check("add_ir_en_cycles", n_ir - b0, 1);
    check("add_alufn", int'(last_alufn), 32);
    check("add_wdsel", int'(last_wdsel), 1);
    check("add_werf", int'(last_werf), 1);
    check("add_pcsel", int'(last_pcsel), 0);

    // BEQ taken / not taken
    instr(6'h1D, 0, 0, 1'b1, 1'b0); settle();
    check("beq_z1_pcsel", int'(last_pcsel), 1);
    check("beq_z1_werf", int'(last_werf), 1);
    check("beq_z1_wdsel", int'(last_wdsel), 0);
    instr(6'h1D, 1, 0, 1'b0, 1'b0); settle();
    check("beq_z0_pcsel", int'(last_pcsel), 0);
    check("beq_z0_werf", int'(last_werf), 1);

    // LD with DMEM_ACK after 3 wait cycles, then zero-wait ST
    b0 = n_dreq;
    instr(6'h18, 0, 3, 1'b0, 1'b0); settle();
    check("ld_dmem_req_cycles", n_dreq - b0, 4);
    check("ld_wdsel", int'(last_wdsel), 2);
    check("ld_werf", int'(last_werf), 1);
    b0 = n_wr;
    instr(6'h19, 0, 0, 1'b0, 1'b0); settle();
    check("st_wr_cycles", n_wr - b0, 1);
    check("st_werf", int'(last_werf), 0);

    // Illegal opcode, then IRQ taken twice back to back (still pending after the trap)
    instr(6'h00, 0, 0, 1'b0, 1'b0); settle();
    check("illop_pcsel", int'(last_pcsel), 3);
    check("illop_wasel", int'(last_wasel), 1);
    check("illop_cause", int'(trap_cause), 1);
    irq_trap(); irq_trap(); settle();
    check("irq_pcsel", int'(last_pcsel), 4);
    check("irq_cause", int'(trap_cause), 2);
    instr(6'h2A, 0, 0, 1'b0, 1'b1); settle();
    check("irq_masked_cause_holds", int'(trap_cause), 2);

    // ST that never gets DMEM_ACK
    b0 = n_wr; b1 = n_ldwb;
    instr(6'h19, 0, 99, 1'b0, 1'b0); settle();
    check("tmo_wr_cycles", n_wr - b0, 4);
    check("tmo_no_load_wb", n_ldwb - b1, 0);
    check("tmo_cause", int'(trap_cause), 3);
    check("tmo_pcsel", int'(last_pcsel), 3);

    // Reset asserted in the middle of a stalled ST
    e = idle(); e.imem_req = 1'b1; e.ir_en = 1'b1;
    cyc("rst_fetch", 6'h19, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e, '1);
    cyc("rst_decode", 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle(), '1);
    e = idle(); e.alufn = 6'h20; e.bsel = 1'b1; e.ra2sel = 1'b1;
    cyc("rst_exec", 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, '1);
    e = idle(); e.dmem_req = 1'b1; e.wr = 1'b1;
    cyc("rst_mem", 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, mem_care());
    @(posedge clk); #1;
    exp_vld = 1'b0; dmem_ack = 1'b0;
    #1;
    check("pre_reset_wr", int'(wr), 1);
    reset_n = 1'b0; #1;
    check("reset_drops_wr", int'(wr), 0);
    check("reset_drops_dmem_req", int'(dmem_req), 0);
    check("reset_no_werf", int'(werf), 0);
    @(posedge clk); #3;
    reset_n = 1'b1; cur_cause = 2'd0; irq = 1'b0; imem_ack = 1'b0;
    #1;
    check("post_reset_imem_req", int'(imem_req), 1);
    check("post_reset_dmem_req", int'(dmem_req), 0);
    check("post_reset_cause", int'(trap_cause), 0);

    // Randomized instruction stream
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        irq_trap();
      end else begin
        sel = $urandom_range(0, 99);
        if (sel < 40) op = 6'($urandom_range(32, 63));
        else if (sel < 75) begin
          case ($urandom_range(0, 5))
            0:       op = 6'h18;
            1:       op = 6'h19;
            2:       op = 6'h1B;
            3:       op = 6'h1D;
            4:       op = 6'h1E;
            default: op = 6'h1F;
          endcase
        end else op = 6'($urandom_range(0, 63));
        instr(op, $urandom_range(0, 3), $urandom_range(0, 5), rb(), ($urandom_range(0, 4) == 0));
      end
    end

    @(posedge clk); #1;
    exp_vld = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
